// File: rtl/ahb_lite_stream_buffer.sv
// AHB-Lite slave fronting a byte FIFO with a byte-stream port on the far side.
// AHB DATA accesses push/pop 1, 2 or 4 bytes; the stream port pushes/pops one
// byte per cycle. Illegal accesses get a two-cycle ERROR response.
module ahb_lite_stream_buffer #(
    parameter int DEPTH      = 64,
    parameter int THRESH_RST = 32,
    localparam int OCC_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsel,
    input  logic [3:0]       haddr,
    input  logic [1:0]       hsize,
    input  logic [1:0]       htrans,
    input  logic             hwrite,
    input  logic [31:0]      hwdata,
    output logic [31:0]      hrdata,
    output logic             hresp,
    output logic             hready,
    input  logic             s_push,
    input  logic [7:0]       s_push_data,
    input  logic             s_pop,
    output logic [7:0]       s_pop_data,
    input  logic             flush,
    output logic [OCC_W-1:0] occupancy,
    output logic             irq
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             ovf_q, ovf_d, unf_q, unf_d, irq_q, irq_d;
    logic             irq_en_q, irq_en_d;
    logic [7:0]       thr_q, thr_d;
    logic [7:0]       s_pop_data_q, s_pop_data_d;
    logic             dp_q, dp_d, err2_q, err2_d;
    logic [3:0]       ap_addr_q, ap_addr_d;
    logic [1:0]       ap_size_q, ap_size_d;
    logic             ap_write_q, ap_write_d;

    logic [1:0] sel, lo, lane;
    int         nb, occ_i, a_push, a_pop;
    logic       misal, ovf_hit, unf_hit, bad, ok, sp_ok, spo_ok, clr, flag_wr;
    logic       unused_htrans;

    assign unused_htrans = htrans[0];
    assign s_pop_data    = s_pop_data_q;
    assign occupancy     = occ_q;
    assign irq           = irq_q;

    // Decode the data phase, drive the AHB response and compute all next state.
    always_comb begin
        sel   = ap_addr_q[3:2];
        lo    = ap_addr_q[1:0];
        lane  = 2'd0;
        occ_i = int'(occ_q);
        case (ap_size_q)
            2'd0:    nb = 1;
            2'd1:    nb = 2;
            2'd2:    nb = 4;
            default: nb = 0;
        endcase
        misal = (ap_size_q == 2'd3) || (ap_size_q == 2'd1 && lo[0]) ||
                (ap_size_q == 2'd2 && lo != 2'd0);
        // FIFO-level errors are judged against the registered occupancy.
        ovf_hit = dp_q && !misal && ap_write_q && sel == 2'd0 && (occ_i + nb > DEPTH);
        unf_hit = dp_q && !misal && !ap_write_q && sel == 2'd0 && (nb > occ_i);
        bad     = dp_q && (misal || (ap_write_q && sel == 2'd1) ||
                           (!ap_write_q && sel == 2'd3) || ovf_hit || unf_hit);
        ok      = dp_q && !bad;
        hready  = !bad;
        hresp   = bad || err2_q;
        err2_d  = bad;

        // Address phase capture; held fields only matter while dp_q is set.
        dp_d       = hsel && htrans[1] && hready;
        ap_addr_d  = dp_d ? haddr  : ap_addr_q;
        ap_size_d  = dp_d ? hsize  : ap_size_q;
        ap_write_d = dp_d ? hwrite : ap_write_q;

        a_push = (ok && ap_write_q && sel == 2'd0) ? nb : 0;
        a_pop  = (ok && !ap_write_q && sel == 2'd0) ? nb : 0;
        // AHB bytes go first; the stream port gets whatever room/data remains.
        sp_ok  = s_push && (occ_i + a_push < DEPTH);
        spo_ok = s_pop && (occ_i - a_pop > 0);

        // Read data: only driven during an OKAY read data phase.
        hrdata = '0;
        if (ok && !ap_write_q) begin
            case (sel)
                2'd0: begin
                    for (int i = 0; i < 4; i++) begin
                        lane = lo + 2'(i);
                        if (i < nb) hrdata[8*lane +: 8] = mem_q[rd_ptr_q + PTR_W'(i)];
                    end
                end
                2'd1: begin
                    hrdata[OCC_W-1:0] = occ_q;
                    hrdata[16]        = (occ_q == '0);
                    hrdata[17]        = (occ_q == OCC_W'(DEPTH));
                    hrdata[18]        = ovf_q;
                    hrdata[19]        = unf_q;
                end
                2'd2: begin
                    hrdata[1]    = irq_en_q;
                    hrdata[15:8] = thr_q;
                end
                default: hrdata = '0;
            endcase
        end

        // Control register and flag-clear writes.
        irq_en_d = irq_en_q;
        thr_d    = thr_q;
        clr      = flush;
        if (ok && ap_write_q && sel == 2'd2) begin
            irq_en_d = hwdata[1];
            thr_d    = hwdata[15:8];
            clr      = flush || hwdata[0];
        end
        flag_wr = ok && ap_write_q && sel == 2'd3;
        ovf_d   = (ovf_q && !(flag_wr && hwdata[18])) || ovf_hit || (s_push && !sp_ok);
        unf_d   = (unf_q && !(flag_wr && hwdata[19])) || unf_hit || (s_pop && !spo_ok);

        // FIFO storage and pointers; a clear wins over every same-cycle access.
        mem_d        = mem_q;
        s_pop_data_d = spo_ok ? mem_q[rd_ptr_q + PTR_W'(a_pop)] :
                       (s_pop ? 8'd0 : s_pop_data_q);
        if (clr) begin
            occ_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                lane = lo + 2'(i);
                if (i < a_push) mem_d[wr_ptr_q + PTR_W'(i)] = hwdata[8*lane +: 8];
            end
            if (sp_ok) mem_d[wr_ptr_q + PTR_W'(a_push)] = s_push_data;
            wr_ptr_d = wr_ptr_q + PTR_W'(a_push + int'(sp_ok));
            rd_ptr_d = rd_ptr_q + PTR_W'(a_pop + int'(spo_ok));
            occ_d    = OCC_W'(occ_i + a_push + int'(sp_ok) - a_pop - int'(spo_ok));
        end

        irq_d = irq_en_q && ((occ_i >= int'(thr_q)) || ovf_q || unf_q);
    end

    // Control state, pointers, flags and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            irq_q        <= 1'b0;
            irq_en_q     <= 1'b0;
            thr_q        <= 8'(THRESH_RST);
            s_pop_data_q <= 8'd0;
            dp_q         <= 1'b0;
            err2_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            irq_q        <= irq_d;
            irq_en_q     <= irq_en_d;
            thr_q        <= thr_d;
            s_pop_data_q <= s_pop_data_d;
            dp_q         <= dp_d;
            err2_q       <= err2_d;
        end
    end

    // Byte storage and captured address-phase fields; contents need no reset.
    always_ff @(posedge clk) begin
        mem_q      <= mem_d;
        ap_addr_q  <= ap_addr_d;
        ap_size_q  <= ap_size_d;
        ap_write_q <= ap_write_d;
    end
endmodule

// File: tb/tb_ahb_lite_stream_buffer.sv
// Directed bench for ahb_lite_stream_buffer (DEPTH=64, THRESH_RST=32).
module tb_ahb_lite_stream_buffer;
    logic        clk = 1'b0;
    logic        rst, hsel, hwrite, s_push, s_pop, flush;
    logic [3:0]  haddr;
    logic [1:0]  hsize, htrans;
    logic [31:0] hwdata, hrdata;
    logic        hresp, hready, irq;
    logic [7:0]  s_push_data, s_pop_data;
    logic [6:0]  occupancy;
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] rd;
    logic        er;

    ahb_lite_stream_buffer #(.DEPTH(64), .THRESH_RST(32)) dut (
        .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .hsize(hsize),
        .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata),
        .hresp(hresp), .hready(hready), .s_push(s_push), .s_push_data(s_push_data),
        .s_pop(s_pop), .s_pop_data(s_pop_data), .flush(flush),
        .occupancy(occupancy), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One AHB transfer: address phase, data phase, and both ERROR cycles if any.
    task automatic ahb(input logic wr, input logic [3:0] addr, input logic [1:0] sz,
                       input logic [31:0] wd, output logic [31:0] rdat, output logic err);
        hsel = 1'b1; htrans = 2'b10; haddr = addr; hsize = sz; hwrite = wr;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        #1;
        rdat = hrdata;
        err  = hresp;
        if (hresp) begin
            chk("err_c1_hready", 32'(hready), 32'd0);
            @(posedge clk); #2;
            chk("err_c2_hresp", 32'(hresp), 32'd1);
            chk("err_c2_hready", 32'(hready), 32'd1);
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic spush(input logic [7:0] b);
        s_push = 1'b1; s_push_data = b;
        @(posedge clk); #1;
        s_push = 1'b0;
    endtask

    task automatic spop(input string tag, input logic [7:0] exp);
        s_pop = 1'b1;
        @(posedge clk); #1;
        s_pop = 1'b0;
        chk(tag, 32'(s_pop_data), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; hsel = 1'b0; hwrite = 1'b0; s_push = 1'b0; s_pop = 1'b0; flush = 1'b0;
        haddr = 4'd0; hsize = 2'd0; htrans = 2'd0; hwdata = 32'd0; s_push_data = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hready", 32'(hready), 32'd1);
        chk("rst_s_pop_data", 32'(s_pop_data), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        #8;
        ahb(1'b0, 4'h8, 2'd2, 32'd0, rd, er);
        chk("rst_ctrl", rd, 32'h0000_2000);
        ahb(1'b0, 4'h4, 2'd2, 32'd0, rd, er);
        chk("rst_status", rd, 32'h0001_0000);

        // Word push, then stream pops come out little-endian.
        ahb(1'b1, 4'h0, 2'd2, 32'h4433_2211, rd, er);
        chk("t1_wr_resp", 32'(er), 32'd0);
        ahb(1'b0, 4'h4, 2'd2, 32'd0, rd, er);
        chk("t1_status", rd, 32'h0000_0004);
        spop("t1_pop0", 8'h11);
        spop("t1_pop1", 8'h22);
        spop("t1_pop2", 8'h33);
        spop("t1_pop3", 8'h44);
        chk("t1_occ", 32'(occupancy), 32'd0);

        // Stream push, half read on the upper lanes.
        spush(8'hAA); spush(8'hBB); spush(8'hCC);
        ahb(1'b0, 4'h2, 2'd1, 32'd0, rd, er);
        chk("t2_half_rd", rd, 32'hBBAA_0000);
        chk("t2_half_resp", 32'(er), 32'd0);
        chk("t2_occ", 32'(occupancy), 32'd1);
        spop("t2_pop", 8'hCC);
        ahb(1'b0, 4'h0, 2'd0, 32'd0, rd, er);
        chk("t2_unf_err", 32'(er), 32'd1);
        ahb(1'b0, 4'h4, 2'd2, 32'd0, rd, er);
        chk("t2_unf_status", rd, 32'h0009_0000);
        ahb(1'b1, 4'hC, 2'd2, 32'h0008_0000, rd, er);
        ahb(1'b0, 4'h4, 2'd2, 32'd0, rd, er);
        chk("t2_unf_clr", rd, 32'h0001_0000);

        // Fill to 62 bytes (byte j holds value j), then overflowing word write.
        for (int k = 0; k < 15; k++)
            ahb(1'b1, 4'h0, 2'd2, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, rd, er);
        ahb(1'b1, 4'h0, 2'd1, 32'h0000_3D3C, rd, er);
        chk("t3_occ62", 32'(occupancy), 32'd62);
        ahb(1'b1, 4'h0, 2'd2, 32'hDEAD_BEEF, rd, er);
        chk("t3_ovf_err", 32'(er), 32'd1);
        chk("t3_occ_kept", 32'(occupancy), 32'd62);
        ahb(1'b0, 4'h4, 2'd2, 32'd0, rd, er);
        chk("t3_status_ovf", rd, 32'h0004_003E);
        ahb(1'b1, 4'hC, 2'd2, 32'h0004_0000, rd, er);
        ahb(1'b0, 4'h4, 2'd2, 32'd0, rd, er);
        chk("t3_status_clr", rd, 32'h0000_003E);

        // Occ 63: AHB byte write and stream push in the same cycle.
        spush(8'h5A);
        hsel = 1'b1; htrans = 2'b10; haddr = 4'h0; hsize = 2'd0; hwrite = 1'b1;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0000_00EE;
        s_push = 1'b1; s_push_data = 8'h77;
        #1;
        chk("t4_resp", 32'(hresp), 32'd0);
        @(posedge clk); #1;
        s_push = 1'b0;
        chk("t4_occ", 32'(occupancy), 32'd64);
        ahb(1'b0, 4'h4, 2'd2, 32'd0, rd, er);
        chk("t4_status", rd, 32'h0006_0040);
        for (int k = 0; k < 16; k++) begin
            ahb(1'b0, 4'h0, 2'd2, 32'd0, rd, er);
            if (k == 0)  chk("t4_first_word", rd, 32'h0302_0100);
            if (k == 15) chk("t4_last_word", rd, 32'hEE5A_3D3C);
        end
        ahb(1'b0, 4'h4, 2'd2, 32'd0, rd, er);
        chk("t4_drained", rd, 32'h0005_0000);
        ahb(1'b1, 4'hC, 2'd2, 32'h0004_0000, rd, er);

        // Threshold interrupt and flush.
        for (int k = 0; k < 10; k++) ahb(1'b1, 4'h0, 2'd2, 32'h0102_0304, rd, er);
        chk("t5_occ40", 32'(occupancy), 32'd40);
        ahb(1'b1, 4'h8, 2'd2, 32'h0000_2002, rd, er);
        @(posedge clk); #1;
        chk("t5_irq_on", 32'(irq), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("t5_flush_occ", 32'(occupancy), 32'd0);
        chk("t5_irq_lag", 32'(irq), 32'd1);
        @(posedge clk); #1;
        chk("t5_irq_off", 32'(irq), 32'd0);

        // CTRL.clear empties the FIFO and reads back as 0.
        spush(8'h01); spush(8'h02);
        ahb(1'b1, 4'h8, 2'd2, 32'h0000_2003, rd, er);
        chk("clr_occ", 32'(occupancy), 32'd0);

        // Illegal accesses leave state alone; CTRL still reads back.
        spush(8'h10); spush(8'h20);
        ahb(1'b1, 4'h0, 2'd3, 32'h1111_1111, rd, er);
        chk("t6_size3", 32'(er), 32'd1);
        ahb(1'b0, 4'h1, 2'd1, 32'd0, rd, er);
        chk("t6_misalign", 32'(er), 32'd1);
        ahb(1'b1, 4'h4, 2'd2, 32'hFFFF_FFFF, rd, er);
        chk("t6_wr_status", 32'(er), 32'd1);
        chk("t6_occ", 32'(occupancy), 32'd2);
        ahb(1'b0, 4'h4, 2'd2, 32'd0, rd, er);
        chk("t6_status", rd, 32'h0000_0002);
        ahb(1'b0, 4'h8, 2'd2, 32'd0, rd, er);
        chk("t6_ctrl", rd, 32'h0000_2002);
        chk("t6_ctrl_resp", 32'(er), 32'd0);
        chk("t6_irq", 32'(irq), 32'd0);

        // Reset during a data phase aborts it.
        hsel = 1'b1; htrans = 2'b10; haddr = 4'h8; hsize = 2'd2; hwrite = 1'b0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_hrdata", hrdata, 32'd0);
        chk("mid_rst_hready", 32'(hready), 32'd1);
        chk("mid_rst_occ", 32'(occupancy), 32'd0);
        ahb(1'b0, 4'h8, 2'd2, 32'd0, rd, er);
        chk("mid_rst_ctrl", rd, 32'h0000_2000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
